// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl -- PC sequencer and instruction-fetch controller.
//
// Keeps one instruction-memory request in flight at a time and hands each
// fetched word to decode over a valid/ready handshake. A redirect from
// execute replaces the PC. If a request is already in flight, its response
// is still awaited and then thrown away (DROP) before the new target is
// fetched.
//
// Optional feature: define FETCH_MISALIGN_CHK_EN to add fetch_misalign_o.
// With it, a redirect to a target whose low two bits are non-zero sets a
// sticky flag. The fetcher then halts, draining any in-flight response first.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   branch_taken_i / branch_target_i    redirect request and target PC
//   instr_mem_req_o / instr_mem_addr_o  fetch request and address
//   instr_mem_gnt_i                     request accepted this cycle
//   instr_mem_rvalid_i / _rdata_i       response for the outstanding request
//   instr_valid_o / instr_o / pc_o      fetched instruction and its PC
//   instr_ready_i                       decode accepts instr_o
//   fetch_misalign_o                    (optional) sticky misaligned-redirect flag
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 19,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               instr_mem_req_o,
    output logic [ADDR_W-1:0]  instr_mem_addr_o,
    input  logic               instr_mem_gnt_i,
    input  logic               instr_mem_rvalid_i,
    input  logic [INSTR_W-1:0] instr_mem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    input  logic               instr_ready_i
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic               fetch_misalign_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP, S_HALT
    } state_e;

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    state_e              state_q, state_d, go_req;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                valid_q, valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pco_q, pco_d;
    logic                redir, bad, halt_pend;
`ifdef FETCH_MISALIGN_CHK_EN
    logic                mis_q, mis_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pco_d     = pco_q;
        redir     = branch_taken_i && (state_q inside {S_REQ, S_WAIT, S_HOLD, S_DROP});
        bad       = 1'b0;
        halt_pend = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        bad       = redir && (branch_target_i[1:0] != 2'b00);
        halt_pend = mis_q || bad;
        mis_d     = halt_pend;
`endif
        // Where a redirect or a drained response leads: normally back to REQ,
        // but to HALT once a misaligned target has been seen.
        go_req = halt_pend ? S_HALT : S_REQ;

        if (redir) begin
            pc_d    = branch_target_i;
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (redir)                state_d = instr_mem_gnt_i ? S_DROP : go_req;
                else if (instr_mem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A redirect that coincides with the response has nothing
                // left in flight, so there is no need to pass through DROP.
                if (redir) begin
                    state_d = instr_mem_rvalid_i ? go_req : S_DROP;
                end else if (instr_mem_rvalid_i) begin
                    instr_d = instr_mem_rdata_i;
                    pco_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Redirect wins over a same-cycle handshake: no PC increment.
                if (redir) begin
                    state_d = go_req;
                end else if (instr_ready_i) begin
                    pc_d    = pc_q + INC;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DROP: if (instr_mem_rvalid_i) state_d = go_req;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            pco_q   <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            // Request and address are registered from the next state, so the
            // address only moves when (re)entering or redirecting within REQ.
            req_q   <= (state_d == S_REQ);
            if (state_d == S_REQ) addr_q <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign instr_mem_req_o  = req_q;
    assign instr_mem_addr_o = addr_q;
    assign instr_valid_o    = valid_q;
    assign instr_o          = instr_q;
    assign pc_o             = pco_q;
`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_misalign_o = mis_q;
`endif

endmodule
